// File: rtl/dprf_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dprf_pkg
//  Description : Shared sizes, requester encoding and helpers for the DPRF
//                writeback arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package dprf_pkg;

    localparam int NREGS = 16;
    localparam int REGW  = 4;
    localparam int DATAW = 32;

    // Requester identity; also the encoding of the round-robin pointer.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

    // One-hot register mask used by the busy scoreboard.
    function automatic logic [NREGS-1:0] reg_onehot(input logic [REGW-1:0] r);
        reg_onehot    = '0;
        reg_onehot[r] = 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dprf_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dprf_wb_arbiter_if
//  Description : Writeback request, issue-claim and DPRF write-port bundle.
//                The master side is the pipeline / register file, the slave
//                side is the writeback arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dprf_wb_arbiter_if;
    import dprf_pkg::*;

    // ALU writeback requester
    logic             alu_valid;
    logic             alu_ready;
    logic [REGW-1:0]  alu_dest;
    logic [DATAW-1:0] alu_data;

    // Memory-load writeback requester
    logic             mem_valid;
    logic             mem_ready;
    logic [REGW-1:0]  mem_dest;
    logic [DATAW-1:0] mem_data;

    // Issue-stage destination claim
    logic             iss_valid;
    logic [REGW-1:0]  iss_dest;
    logic [REGW-1:0]  iss_src0;
    logic [REGW-1:0]  iss_src1;
    logic             iss_stall;

    // DPRF write port and scoreboard
    logic             rf_we;
    logic [REGW-1:0]  rf_dest;
    logic [DATAW-1:0] rf_data;
    logic [NREGS-1:0] busy;

    modport master (
        output alu_valid, alu_dest, alu_data,
        input  alu_ready,
        output mem_valid, mem_dest, mem_data,
        input  mem_ready,
        output iss_valid, iss_dest, iss_src0, iss_src1,
        input  iss_stall,
        input  rf_we, rf_dest, rf_data, busy
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data,
        output alu_ready,
        input  mem_valid, mem_dest, mem_data,
        output mem_ready,
        input  iss_valid, iss_dest, iss_src0, iss_src1,
        output iss_stall,
        output rf_we, rf_dest, rf_data, busy
    );

endinterface
`default_nettype wire

// File: rtl/dprf_wb_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-requester round-robin arbiter. Bit 0 is the ALU, bit 1
//                the load path. After any grant the pointer moves to the
//                requester that was not granted; it holds when idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import dprf_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic [1:0] req,
    output logic      [1:0] gnt
);

    req_e r_prio;

    // Grant is combinational; nothing is granted while reset is held.
    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            if (req == 2'b11) begin
                gnt = (r_prio == REQ_ALU) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    // Pointer moves to the other requester after every grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio <= REQ_ALU;
        end else if (gnt[0]) begin
            r_prio <= REQ_MEM;
        end else if (gnt[1]) begin
            r_prio <= REQ_ALU;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dprf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dprf_wb_arbiter
//  Description : Shares the DPRF write port between the ALU and load-path
//                writeback requesters, registers the selected write, and
//                tracks pending writes per register to stall issue on
//                RAW/WAW hazards.
//  Revision    : 1.0 - initial release
// ============================================================================
module dprf_wb_arbiter
    import dprf_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         reset,
    dprf_wb_arbiter_if.slave  bus
);

    logic [1:0]       w_gnt;
    logic             w_xfer;
    logic [REGW-1:0]  w_wr_dest;
    logic [DATAW-1:0] w_wr_data;
    logic             w_claim;
    logic             w_stall;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;

    logic             r_rf_we;
    logic [REGW-1:0]  r_rf_dest;
    logic [DATAW-1:0] r_rf_data;
    logic [NREGS-1:0] r_busy;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({bus.mem_valid, bus.alu_valid}),
        .gnt   (w_gnt)
    );

    assign bus.alu_ready = w_gnt[0];
    assign bus.mem_ready = w_gnt[1];

    // A grant is the transfer, since ready is only raised for a valid requester.
    assign w_xfer    = |w_gnt;
    assign w_wr_dest = w_gnt[1] ? bus.mem_dest : bus.alu_dest;
    assign w_wr_data = w_gnt[1] ? bus.mem_data : bus.alu_data;

    // Stall on any pending write to a source (RAW) or the destination (WAW).
    // Reset is gated in because busy only clears at the reset edge.
    assign w_stall = bus.iss_valid && !reset &&
                     (r_busy[bus.iss_src0] | r_busy[bus.iss_src1] | r_busy[bus.iss_dest]);
    assign w_claim = bus.iss_valid && !w_stall;

    assign w_set = w_claim ? reg_onehot(bus.iss_dest) : '0;
    assign w_clr = r_rf_we ? reg_onehot(r_rf_dest)    : '0;

    // Output register: one-cycle write pulse towards the DPRF per transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rf_we   <= 1'b0;
            r_rf_dest <= '0;
            r_rf_data <= '0;
        end else begin
            r_rf_we <= w_xfer;
            if (w_xfer) begin
                r_rf_dest <= w_wr_dest;
                r_rf_data <= w_wr_data;
            end
        end
    end

    // Scoreboard: clear on the DPRF write edge, set on an accepted claim;
    // the set is applied last so it wins a same-register collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    assign bus.iss_stall = w_stall;
    assign bus.rf_we     = r_rf_we;
    assign bus.rf_dest   = r_rf_dest;
    assign bus.rf_data   = r_rf_data;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dprf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dprf_wb_arbiter
//  Description : Self-checking bench for dprf_wb_arbiter: per-cycle vector
//                table for arbitration, hand sequences for hazards, the
//                set/clear collision and reset mid-flight; written values
//                are checked through a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dprf_wb_arbiter;
    import dprf_pkg::*;

    typedef struct {
        logic        av;
        logic [3:0]  ad;
        logic [31:0] adat;
        logic        mv;
        logic [3:0]  md;
        logic [31:0] mdat;
        logic        ear;
        logic        emr;
    } vec_t;

    typedef struct packed {
        logic [3:0]  d;
        logic [31:0] v;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    wr_t  sb[$];
    logic [31:0] rf_model [16];
    vec_t vecs [18];

    dprf_wb_arbiter_if bus ();

    dprf_wb_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic av, input logic [3:0] ad, input logic [31:0] adat,
                                input logic mv, input logic [3:0] md, input logic [31:0] mdat,
                                input logic ear, input logic emr);
        vec_t v;
        v.av = av; v.ad = ad; v.adat = adat;
        v.mv = mv; v.md = md; v.mdat = mdat;
        v.ear = ear; v.emr = emr;
        return v;
    endfunction

    task automatic push(input logic [3:0] d, input logic [31:0] v);
        wr_t e;
        e.d = d;
        e.v = v;
        sb.push_back(e);
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0; bus.alu_dest = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_dest = '0; bus.mem_data = '0;
        bus.iss_valid = 1'b0; bus.iss_dest = '0; bus.iss_src0 = '0; bus.iss_src1 = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
    endtask

    // DPRF model: written on the edge where rf_we is high.
    always @(posedge clk) begin
        if (bus.rf_we === 1'b1) rf_model[bus.rf_dest] <= bus.rf_data;
    end

    // Scoreboard consumer: every write pulse must match the oldest accepted request.
    always @(posedge clk) begin
        #2;
        if (bus.rf_we === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rf_we_unexpected: got write r%0d=%0h expected no write (t=%0t)",
                         bus.rf_dest, bus.rf_data, $time);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("rf_dest", {28'd0, bus.rf_dest}, {28'd0, e.d});
                chk("rf_data", bus.rf_data, e.v);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // ALU only, idle, mem only to park prio on ALU, then contention sequences.
        vecs[0]  = mk(1, 4'd3,  32'd30,    0, 4'd0,  32'h0,     1, 0);
        vecs[1]  = mk(0, 4'd0,  32'h0,     0, 4'd0,  32'h0,     0, 0);
        vecs[2]  = mk(0, 4'd0,  32'h0,     1, 4'd9,  32'h99,    0, 1);
        vecs[3]  = mk(1, 4'd10, 32'd100,   1, 4'd5,  32'd7,     1, 0);
        vecs[4]  = mk(0, 4'd0,  32'h0,     1, 4'd5,  32'd7,     0, 1);
        vecs[5]  = mk(1, 4'd11, 32'hB,     1, 4'd12, 32'hC,     1, 0);
        vecs[6]  = mk(1, 4'd13, 32'hD,     1, 4'd12, 32'hC,     0, 1);
        vecs[7]  = mk(1, 4'd13, 32'hD,     1, 4'd14, 32'hE,     1, 0);
        vecs[8]  = mk(0, 4'd0,  32'h0,     1, 4'd14, 32'hE,     0, 1);
        vecs[9]  = mk(0, 4'd0,  32'h0,     1, 4'd1,  32'h101,   0, 1);
        vecs[10] = mk(0, 4'd0,  32'h0,     1, 4'd2,  32'h102,   0, 1);
        vecs[11] = mk(0, 4'd0,  32'h0,     1, 4'd3,  32'h103,   0, 1);
        vecs[12] = mk(0, 4'd0,  32'h0,     1, 4'd4,  32'h104,   0, 1);
        vecs[13] = mk(0, 4'd0,  32'h0,     0, 4'd0,  32'h0,     0, 0);
        vecs[14] = mk(1, 4'd6,  32'h60,    1, 4'd6,  32'h61,    1, 0);
        vecs[15] = mk(0, 4'd0,  32'h0,     1, 4'd6,  32'h61,    0, 1);
        vecs[16] = mk(0, 4'd0,  32'h0,     0, 4'd0,  32'h0,     0, 0);
        vecs[17] = mk(0, 4'd0,  32'h0,     0, 4'd0,  32'h0,     0, 0);

        // Reset with every requester asserting: nothing may be granted.
        reset = 1'b1;
        idle_inputs();
        bus.alu_valid = 1'b1; bus.alu_dest = 4'd2;
        bus.mem_valid = 1'b1; bus.mem_dest = 4'd4;
        bus.iss_valid = 1'b1; bus.iss_dest = 4'd1;
        probe();
        chk("reset_rf_we",     {31'd0, bus.rf_we},     32'd0);
        chk("reset_rf_dest",   {28'd0, bus.rf_dest},   32'd0);
        chk("reset_rf_data",   bus.rf_data,            32'd0);
        chk("reset_busy",      {16'd0, bus.busy},      32'd0);
        chk("reset_alu_ready", {31'd0, bus.alu_ready}, 32'd0);
        chk("reset_mem_ready", {31'd0, bus.mem_ready}, 32'd0);
        chk("reset_iss_stall", {31'd0, bus.iss_stall}, 32'd0);
        cyc();
        reset = 1'b0;
        idle_inputs();

        // Table: one vector per cycle.
        for (int i = 0; i < 18; i++) begin
            cyc();
            bus.alu_valid = vecs[i].av; bus.alu_dest = vecs[i].ad; bus.alu_data = vecs[i].adat;
            bus.mem_valid = vecs[i].mv; bus.mem_dest = vecs[i].md; bus.mem_data = vecs[i].mdat;
            probe();
            chk($sformatf("v%0d_alu_ready", i), {31'd0, bus.alu_ready}, {31'd0, vecs[i].ear});
            chk($sformatf("v%0d_mem_ready", i), {31'd0, bus.mem_ready}, {31'd0, vecs[i].emr});
            chk($sformatf("v%0d_busy", i), {16'd0, bus.busy}, 32'd0);
            if (vecs[i].ear) push(vecs[i].ad, vecs[i].adat);
            if (vecs[i].emr) push(vecs[i].md, vecs[i].mdat);
        end
        chk("table_sb_drained", sb.size(), 32'd0);

        // Hazard: claim r3, RAW on r3 stalls until the writeback clears it.
        cyc();
        idle_inputs();
        bus.iss_valid = 1'b1; bus.iss_dest = 4'd3;
        probe();
        chk("haz_first_claim_stall", {31'd0, bus.iss_stall}, 32'd0);
        cyc();
        bus.iss_dest = 4'd3; bus.iss_src0 = 4'd3;
        bus.alu_valid = 1'b1; bus.alu_dest = 4'd3; bus.alu_data = 32'h33;
        probe();
        chk("haz_busy_set",  {16'd0, bus.busy},      32'h0008);
        chk("haz_raw_stall", {31'd0, bus.iss_stall}, 32'd1);
        chk("haz_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
        push(4'd3, 32'h33);
        cyc();
        bus.alu_valid = 1'b0;
        probe();
        chk("haz_rfwe_cycle_busy",  {16'd0, bus.busy},      32'h0008);
        chk("haz_rfwe_cycle_stall", {31'd0, bus.iss_stall}, 32'd1);
        cyc();
        probe();
        chk("haz_cleared_busy",  {16'd0, bus.busy},      32'd0);
        chk("haz_cleared_stall", {31'd0, bus.iss_stall}, 32'd0);

        // Set/clear collision on r7.
        cyc();
        idle_inputs();
        bus.alu_valid = 1'b1; bus.alu_dest = 4'd7; bus.alu_data = 32'h77;
        probe();
        chk("col_busy_before", {16'd0, bus.busy},      32'h0008);
        chk("col_alu_ready",   {31'd0, bus.alu_ready}, 32'd1);
        push(4'd7, 32'h77);
        cyc();
        idle_inputs();
        bus.iss_valid = 1'b1; bus.iss_dest = 4'd7; bus.iss_src0 = 4'd1; bus.iss_src1 = 4'd2;
        probe();
        chk("col_claim_stall", {31'd0, bus.iss_stall}, 32'd0);
        chk("col_rf_we",       {31'd0, bus.rf_we},     32'd1);
        cyc();
        idle_inputs();
        bus.alu_valid = 1'b1; bus.alu_dest = 4'd1; bus.alu_data = 32'h11;
        probe();
        chk("col_busy_set_wins", {16'd0, bus.busy}, 32'h0088);
        chk("pre_rst_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
        push(4'd1, 32'h11);

        // Reset while a write is staged and busy = 0x0088.
        cyc();
        reset = 1'b1;
        bus.mem_valid = 1'b1; bus.mem_dest = 4'd2; bus.mem_data = 32'h22;
        bus.iss_valid = 1'b1; bus.iss_dest = 4'd3; bus.iss_src0 = 4'd3;
        probe();
        chk("rst_mid_rf_we",     {31'd0, bus.rf_we},     32'd1);
        chk("rst_mid_busy",      {16'd0, bus.busy},      32'h0088);
        chk("rst_mid_alu_ready", {31'd0, bus.alu_ready}, 32'd0);
        chk("rst_mid_mem_ready", {31'd0, bus.mem_ready}, 32'd0);
        chk("rst_mid_iss_stall", {31'd0, bus.iss_stall}, 32'd0);
        cyc();
        probe();
        chk("rst_after_rf_we",     {31'd0, bus.rf_we},     32'd0);
        chk("rst_after_busy",      {16'd0, bus.busy},      32'd0);
        chk("rst_after_alu_ready", {31'd0, bus.alu_ready}, 32'd0);
        chk("rst_after_mem_ready", {31'd0, bus.mem_ready}, 32'd0);
        cyc();
        reset = 1'b0;
        bus.iss_valid = 1'b0;
        probe();
        chk("rearb_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
        chk("rearb_mem_ready", {31'd0, bus.mem_ready}, 32'd0);
        push(4'd1, 32'h11);
        cyc();
        bus.alu_valid = 1'b0;
        probe();
        chk("rearb_mem_second", {31'd0, bus.mem_ready}, 32'd1);
        push(4'd2, 32'h22);
        cyc();
        idle_inputs();
        repeat (3) cyc();

        chk("final_sb_drained", sb.size(),    32'd0);
        chk("dprf_r3",          rf_model[3],  32'h33);
        chk("dprf_r4",          rf_model[4],  32'h104);
        chk("dprf_r6_last",     rf_model[6],  32'h61);
        chk("dprf_r7",          rf_model[7],  32'h77);
        chk("dprf_r10",         rf_model[10], 32'd100);
        chk("dprf_r2",          rf_model[2],  32'h22);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dprf_wb_arbiter.md
# dprf_wb_arbiter

Writeback controller for the 16 x 32-bit dual-port register file (DPRF). It shares the DPRF's single write port between two writeback requesters, the ALU and the memory-load path, using round-robin arbitration and valid/ready handshakes. It also keeps a per-register busy scoreboard that stalls instruction issue on RAW/WAW hazards. It sits between the execute/memory stages and the DPRF `we` / `regsel_dest` / `datain` inputs.

## Interface
- `NREGS`, 16, number of architectural registers
- `REGW`, 4, register-select width
- `DATAW`, 32, data width
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `alu_valid`  in  1  ALU writeback request
- `alu_ready`  out  1  ALU request accepted this cycle
- `alu_dest`  in  REGW  ALU destination register
- `alu_data`  in  DATAW  ALU result
- `mem_valid`, `mem_ready`, `mem_dest`, `mem_data`: same as the ALU set, for the load path
- `iss_valid`  in  1  issue stage presents an instruction
- `iss_dest`  in  REGW  destination to claim
- `iss_src0`, `iss_src1`  in  REGW  source registers
- `iss_stall`  out  1  issue must hold; claim not taken
- `rf_we`  out  1  to DPRF `we`
- `rf_dest`  out  REGW  to DPRF `regsel_dest`
- `rf_data`  out  DATAW  to DPRF `datain`
- `busy`  out  NREGS  scoreboard; bit d = write to rd pending

## Operation
- Handshake: a transfer occurs when `valid && ready`. The requester holds valid, dest and data stable until accepted. Ready is combinational from both valids and `prio`.
- Arbitration (1-bit `prio`, reset = ALU):
  - Both valid: grant the requester named by `prio`; `prio` then points to the other requester.
  - One valid: grant it; `prio` then points to the other requester.
  - None valid: `prio` unchanged.
- Only one ready is ever high. No grant occurs while `reset` = 1.
- Output register: a transfer in cycle N gives `rf_we`=1, `rf_dest`, `rf_data` in cycle N+1. `rf_we`=0 in any cycle following no transfer.
- Sustained throughput is one write per cycle.
- Scoreboard:
  - Set: `busy[iss_dest]` is set at the edge where `iss_valid && !iss_stall`.
  - Clear: `busy[rf_dest]` is cleared at the edge where `rf_we`=1, the same edge on which the DPRF writes.
  - Set and clear of the same register at one edge: set wins.
  - A writeback to a non-busy register is still written; its clear is a no-op.
- Stall: `iss_stall = iss_valid && (busy[iss_src0] | busy[iss_src1] | busy[iss_dest])`, combinational. It is 0 when `iss_valid`=0 or `reset`=1.
- All 16 registers are tracked. There is no hardwired zero register.
- Two requests to the same dest are serialized in grant order; the later grant's value ends up in the DPRF.

## Timing
- Reset values: `busy`=0, `rf_we`=0, `rf_dest`=0, `rf_data`=0, `prio`=ALU. `alu_ready`, `mem_ready` and `iss_stall` are held 0 while `reset`=1.
- Reset mid-operation: a write staged in the output register is dropped (`rf_we`=0 the cycle after the reset edge) and all busy bits clear. A requester still holding valid is re-arbitrated after reset deasserts.
- Accept-to-`rf_we` latency: 1 cycle.
- Accept to data readable from the DPRF: 2 edges.
- Busy clear to `iss_stall` low: same cycle as the clear, since `iss_stall` is combinational from registered `busy`.

## Structure
- Package `dprf_pkg`: `NREGS`, `REGW`, `DATAW`, and enum `req_e` {`REQ_ALU`=0, `REQ_MEM`=1} used for `prio`.
- Sub-module `rr_arb2`: two-requester round-robin arbiter holding `prio`, with outputs `gnt[1:0]`.
- Scoreboard, stall logic and output register are written inline.

## Test plan
- ALU only: after reset, `alu_valid`=1, `alu_dest`=3, `alu_data`=30 → `alu_ready`=1 the same cycle; next cycle `rf_we`=1, `rf_dest`=3, `rf_data`=30 for exactly one cycle; the DPRF then reads r3 = 30.
- Contention: `prio`=ALU; ALU (r10, 100) and mem (r5, 7) both valid in cycle 0 → ALU granted in cycle 0, mem in cycle 1; `rf_we` high in cycles 1–2 writing r10=100 then r5=7; `prio`=ALU afterwards.
- Hazard: issue with dest=3 → `busy[3]`=1; next issue with src0=3 → `iss_stall`=1; ALU writeback to r3 → `busy[3]` clears at the `rf_we` edge and `iss_stall` drops in that same following cycle.
- Set/clear collision: `rf_we` to r7 while an issue claims dest=7 at the same edge → `busy[7]` remains 1.
- Back-to-back: `mem_valid` held for 4 cycles with dest 1..4 → `mem_ready` high all 4 cycles; `rf_we` high for 4 consecutive cycles with matching dest/data.
- Reset mid-flight: assert `reset` while `rf_we`=1 and `busy`=16'h0088 → next cycle `rf_we`=0 and `busy`=0; both readys stay 0 until `reset` deasserts.
